// File: rtl/neuron_flit_scheduler.sv
// neuron_flit_scheduler
// Feeds the neuron packet decoder from the per-VC router ejection FIFOs.
// One VC is chosen per packet by round-robin and stays locked until its tail
// flit is delivered. The decoder handshake (activate/stall/class/flit) is
// produced so that it tracks the decoder's own IDLE/SET_TYPE/BUFFER/STALL/WRITE
// walk cycle for cycle. While the decoder has nothing useful to consume it is
// fed a head-coded bubble, which the decoder ignores.

module neuron_flit_scheduler #(
    parameter int  FLIT_WIDTH      = 38,
    parameter int  VIRTUAL_CHANNEL = 4,
    parameter int  PAYLOAD_WIDTH   = 32,
    localparam int VC_IDX_W        = (VIRTUAL_CHANNEL > 1) ? $clog2(VIRTUAL_CHANNEL) : 1
) (
    input  logic                                  neuron_clk,
    input  logic                                  neuron_rst,
    input  logic [VIRTUAL_CHANNEL-1:0]            vc_valid,
    input  logic [VIRTUAL_CHANNEL*FLIT_WIDTH-1:0] vc_flit,
    input  logic                                  hold_in,
    output logic [VIRTUAL_CHANNEL-1:0]            vc_pop,
    output logic [FLIT_WIDTH-1:0]                 flit_out,
    output logic                                  activate_decoder,
    output logic                                  stall_decoder,
    output logic [2:0]                            class_type_out,
    output logic [VC_IDX_W-1:0]                   grant_vc,
    output logic                                  busy,
    output logic                                  proto_err
);

    // Flit layout: header on top, VC one-hot below it, payload at the bottom.
    localparam int HDR_LSB = PAYLOAD_WIDTH + VIRTUAL_CHANNEL;

    localparam logic [1:0] HDR_HEAD = 2'b10;
    localparam logic [1:0] HDR_TAIL = 2'b01;

    // Head-coded all-zero flit; the decoder discards head-coded flits.
    localparam logic [FLIT_WIDTH-1:0] BUBBLE = {HDR_HEAD, {(FLIT_WIDTH-2){1'b0}}};

    localparam logic [VC_IDX_W-1:0] LAST_VC = VC_IDX_W'(VIRTUAL_CHANNEL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STREAM,
        S_HOLD,
        S_WRITE
    } state_t;

    state_t                state;
    logic [VC_IDX_W-1:0]   rr_ptr;

    logic [FLIT_WIDTH-1:0] vc_flit_arr [VIRTUAL_CHANNEL];

    logic                  cand_found;
    logic [VC_IDX_W-1:0]   cand_idx;
    logic [VC_IDX_W-1:0]   cand_next;
    logic [1:0]            cand_hdr;
    logic [2:0]            cand_class;
    logic                  cand_is_head;

    logic                  lock_ready;
    logic [1:0]            lock_hdr;
    logic [FLIT_WIDTH-1:0] lock_flit;

    // Split the flattened FIFO front bus into one flit per VC.
    always_comb begin
        for (int v = 0; v < VIRTUAL_CHANNEL; v++) begin
            vc_flit_arr[v] = vc_flit[v*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    // Round-robin search: first valid VC at or above rr_ptr, wrapping to 0.
    always_comb begin
        logic [VC_IDX_W:0] probe_sum;
        logic [VC_IDX_W-1:0] probe_idx;
        probe_sum  = '0;
        probe_idx  = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = 0; i < VIRTUAL_CHANNEL; i++) begin
            probe_sum = {1'b0, rr_ptr} + (VC_IDX_W+1)'(i);
            if (probe_sum >= (VC_IDX_W+1)'(VIRTUAL_CHANNEL)) begin
                probe_sum = probe_sum - (VC_IDX_W+1)'(VIRTUAL_CHANNEL);
            end
            probe_idx = probe_sum[VC_IDX_W-1:0];
            if (!cand_found && vc_valid[probe_idx]) begin
                cand_found = 1'b1;
                cand_idx   = probe_idx;
            end
        end
    end

    // Decode the candidate's front flit and the locked VC's front flit.
    always_comb begin
        cand_hdr     = vc_flit_arr[cand_idx][HDR_LSB +: 2];
        cand_class   = vc_flit_arr[cand_idx][2:0];
        cand_is_head = (cand_hdr == HDR_HEAD);
        cand_next    = (cand_idx == LAST_VC) ? '0 : cand_idx + VC_IDX_W'(1);
        lock_flit    = vc_flit_arr[grant_vc];
        lock_hdr     = lock_flit[HDR_LSB +: 2];
        lock_ready   = vc_valid[grant_vc] && !hold_in;
    end

    // Decoder-facing strobes; forced quiet while reset is asserted so nothing
    // is popped from the FIFOs during reset.
    always_comb begin
        flit_out         = BUBBLE;
        vc_pop           = '0;
        activate_decoder = 1'b0;
        stall_decoder    = 1'b0;
        busy             = 1'b0;
        if (neuron_rst) begin
            unique case (state)
                S_IDLE, S_WRITE: begin
                    if (cand_found) begin
                        vc_pop           = VIRTUAL_CHANNEL'(1) << cand_idx;
                        activate_decoder = cand_is_head;
                    end
                end
                S_SETUP: begin
                    busy = 1'b1;
                end
                S_STREAM: begin
                    busy = 1'b1;
                    if (lock_ready) begin
                        flit_out = lock_flit;
                        vc_pop   = VIRTUAL_CHANNEL'(1) << grant_vc;
                    end else begin
                        stall_decoder = 1'b1;
                    end
                end
                S_HOLD: begin
                    busy          = 1'b1;
                    stall_decoder = !lock_ready;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

    // Packet sequencing FSM together with the registered arbitration results.
    always_ff @(posedge neuron_clk or negedge neuron_rst) begin
        if (!neuron_rst) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            grant_vc       <= '0;
            class_type_out <= '0;
            proto_err      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_WRITE: begin
                    if (cand_found && cand_is_head) begin
                        class_type_out <= cand_class;
                        grant_vc       <= cand_idx;
                        rr_ptr         <= cand_next;
                        state          <= S_SETUP;
                    end else if (cand_found) begin
                        proto_err <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (lock_ready) begin
                        if (lock_hdr == HDR_TAIL) begin
                            state <= S_WRITE;
                        end else if (lock_hdr == HDR_HEAD) begin
                            proto_err <= 1'b1;
                        end
                    end else begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (lock_ready) begin
                        state <= S_STREAM;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/neuron_flit_scheduler.md
# neuron_flit_scheduler

Sequences NoC flits from the per-virtual-channel input FIFOs into the neuron's packet decoder. It picks one VC per packet by round-robin and locks that VC until the tail flit is delivered. It drives the decoder's `activate_decoder`, `stall_decoder`, `class_type_in` and `flit_in` cycle-exactly, mirroring the decoder's IDLE/SET_TYPE/BUFFER/STALL/WRITE sequence. It sits between the router ejection FIFOs and the decoder inside each neuron core.

## Interface
- `FLIT_WIDTH`, 38, flit width: [37:36] header, [35:32] VC one-hot, [31:0] payload
- `VIRTUAL_CHANNEL`, 4, number of input VCs
- `PAYLOAD_WIDTH`, 32, payload width

Ports:
- `neuron_clk`  in  1  clock
- `neuron_rst`  in  1  reset, asynchronous, active-low
- `vc_valid`  in  VIRTUAL_CHANNEL  FIFO non-empty, one bit per VC
- `vc_flit`  in  VIRTUAL_CHANNEL*FLIT_WIDTH  FIFO front flits; VC i at [i*FLIT_WIDTH +: FLIT_WIDTH]
- `hold_in`  in  1  core cannot accept flits, e.g. memory busy
- `vc_pop`  out  VIRTUAL_CHANNEL  one-hot pop strobe
- `flit_out`  out  FLIT_WIDTH  to decoder `flit_in`
- `activate_decoder`  out  1
- `stall_decoder`  out  1
- `class_type_out`  out  3  to decoder `class_type_in`
- `grant_vc`  out  2  index of the locked VC
- `busy`  out  1  packet in flight
- `proto_err`  out  1  sticky framing error

## Operation
- **Header codes:** 2'b10 head, 2'b00 body, 2'b01 tail. Head payload[2:0] = class type (0 spike, 1 weight, 2 initialize).
- **BUBBLE:** {2'b10, 36'b0}. The decoder ignores head-coded flits, so the bubble is a safe idle value.
- **Output timing:** `flit_out`, `vc_pop`, `activate_decoder` and `stall_decoder` are combinational from the state register and inputs. `class_type_out`, `grant_vc`, `rr_ptr` and `proto_err` are registered.
- **States:** S_IDLE, S_SETUP, S_STREAM, S_HOLD, S_WRITE.

State behaviour:
- **S_IDLE and S_WRITE (arbitrate):**
  - `flit_out` = BUBBLE.
  - Candidate = first valid VC searching from `rr_ptr` upward, with wrap.
  - Candidate front is head: pop it, assert `activate_decoder`, register `class_type_out` <= payload[2:0], `grant_vc` <= candidate, `rr_ptr` <= candidate+1 mod VC. Next state S_SETUP.
  - Candidate front is not a head: pop and discard it, set `proto_err`, no activate. Next state S_IDLE.
  - No valid VC: next state S_IDLE.
- **S_SETUP:** decoder is in SET_TYPE and latches `class_type_out`. `flit_out` = BUBBLE, no pop. Next state S_STREAM.
- **S_STREAM:** decoder is in BUFFER and consumes `flit_out` this cycle.
  - Locked VC valid and !`hold_in`:
    - `flit_out` = front flit, pop it.
    - Tail: next S_WRITE.
    - Head: set `proto_err` and stay. The decoder ignores it.
    - Otherwise stay.
  - Else: `flit_out` = BUBBLE, `stall_decoder`=1, next S_HOLD.
- **S_HOLD:** decoder is in STALL. `flit_out` = BUBBLE, no pop.
  - `stall_decoder` = !(locked VC valid && !`hold_in`).
  - When that deasserts, next S_STREAM. Otherwise stay.
- **Packet lock:** the locked VC is the only one popped between head and tail.
- **`busy`:** 1 in S_SETUP, S_STREAM and S_HOLD.

## Timing
- **Reset:**
  - State S_IDLE, `rr_ptr`=0, `grant_vc`=0, `class_type_out`=0, `proto_err`=0.
  - `flit_out`=BUBBLE; `vc_pop`, `activate_decoder`, `stall_decoder`, `busy` all 0.
- **Latency:** head popped in cycle T (activate). First body flit presented at T+2. An N-flit packet with no stalls occupies T..T+N+1, and the next head can activate at T+N+1 (the S_WRITE cycle).
- **One pop per cycle:** at most one `vc_pop` bit per cycle, never to a VC with `vc_valid`=0.
- **`hold_in` mid-packet:** the cycle in which `hold_in` rises presents BUBBLE + stall. No flit is popped while `hold_in`=1.
- **Reset mid-packet:** returns to S_IDLE immediately. Unpopped flits remain in the FIFOs.
- **Tail and new head together:** a head arriving on another VC in the same cycle the tail is popped is arbitrated in the following S_WRITE cycle.
- **`proto_err`:** cleared only by reset.

## Test plan
- **Single packet:** VC2 holds head(class=1), 2 body, tail -> activate at T, `class_type_out`=1 from T+1, body flits on `flit_out` at T+2 and T+3, tail at T+4, S_WRITE at T+5, `vc_pop[2]` exactly 4 times.
- **Round-robin:** VC0 and VC3 each hold a 1-body packet, `rr_ptr`=0 -> VC0 granted first, VC3 activated in VC0's S_WRITE cycle, `rr_ptr`=0 after both.
- **Gap in locked VC:** VC1 empties after head+body -> BUBBLE with `stall_decoder`=1, state S_HOLD; refill -> `stall_decoder`=0 for one BUBBLE cycle, then tail presented the next cycle.
- **`hold_in` pulse:** 3 cycles of `hold_in` mid-packet -> zero pops during the pulse, BUBBLE/stall, no flit lost or duplicated.
- **Framing error:** VC0 front is a body flit while idle -> popped, `proto_err`=1, no activate; a later valid packet still completes correctly.
- **Reset mid-packet:** assert reset in S_STREAM -> all outputs return to reset values asynchronously, and the remaining FIFO flits are untouched.
